keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner_pkg.sv | 30 +++
 rtl/keypad_debounce.sv | 51 +++++
 rtl/keypad_scanner.sv | 175 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x3 keypad scanner: key-to-output-bit map,
// frame bit indexing and the row-scan state type.
package keypad_scanner_pkg;

  localparam int FRAME_W  = 12;
  localparam int KEYPAD_W = 10;

  localparam int KEY_1_BIT = 9;
  localparam int KEY_2_BIT = 8;
  localparam int KEY_3_BIT = 7;
  localparam int KEY_4_BIT = 6;
  localparam int KEY_5_BIT = 5;
  localparam int KEY_6_BIT = 4;
  localparam int KEY_7_BIT = 3;
  localparam int KEY_8_BIT = 2;
  localparam int KEY_9_BIT = 1;
  localparam int KEY_0_BIT = 0;

  typedef enum logic [1:0] {
    ROW0 = 2'd0,
    ROW1 = 2'd1,
    ROW2 = 2'd2,
    ROW3 = 2'd3
  } scan_state_t;

  function automatic int frame_idx(input int row, input int col);
    return row * 3 + col;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: a frame is committed once it has matched its
// predecessor for DEBOUNCE consecutive frames.
module keypad_debounce
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               i_frame_valid,
  input  logic [FRAME_W-1:0] i_frame,
  output logic [FRAME_W-1:0] o_committed
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [FRAME_W-1:0] r_prev;
  logic [FRAME_W-1:0] r_committed;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_next;

  always_comb begin
    w_count_next = r_count;
    if (i_frame != r_prev) begin
      w_count_next = '0;
    end else if (r_count != CNT_MAX) begin
      w_count_next = r_count + CNT_ONE;
    end else begin
      w_count_next = r_count;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_prev      <= '0;
      r_count     <= '0;
      r_committed <= '0;
    end else if (i_frame_valid) begin
      r_prev  <= i_frame;
      r_count <= w_count_next;
      if (w_count_next == CNT_MAX) begin
        r_committed <= i_frame;
      end
    end
  end

  assign o_committed = r_committed;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: row scan, column sync, debounce and one-hot digit decode.
// Optional KEYPAD_AUX_KEYS_EN adds stop_key (*) and clr_key (#) outputs.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [2:0]          cols,
  output logic [3:0]          rows,
  output logic [KEYPAD_W-1:0] keypad,
  output logic                key_strobe
`ifdef KEYPAD_AUX_KEYS_EN
  ,
  output logic                stop_key,
  output logic                clr_key
`endif
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

  logic [2:0]          r_sync1;
  logic [2:0]          r_sync2;
  scan_state_t         r_state;
  logic [SLOT_W-1:0]   r_slot;
  logic [3:0]          r_rows;
  logic [FRAME_W-1:0]  r_frame;
  logic [KEYPAD_W-1:0] r_keypad;
  logic                r_strobe;

  logic                w_slot_last;
  logic                w_frame_valid;
  logic [2:0]          w_row_bits;
  logic [FRAME_W-1:0]  w_frame_next;
  logic [FRAME_W-1:0]  w_committed;
  logic [KEYPAD_W-1:0] w_digits;
  logic [KEYPAD_W-1:0] w_keypad_next;
  logic [3:0]          w_key_count;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_sync1 <= 3'b111;
      r_sync2 <= 3'b111;
    end else begin
      r_sync1 <= cols;
      r_sync2 <= r_sync1;
    end
  end

  assign w_slot_last   = (r_slot == SLOT_LAST);
  assign w_frame_valid = w_slot_last && (r_state == ROW3);

  // Without the aux feature, * and # can never appear in a frame.
  always_comb begin
    w_row_bits = ~r_sync2;
`ifdef KEYPAD_AUX_KEYS_EN
    w_row_bits = ~r_sync2;
`else
    if (r_state == ROW3) begin
      w_row_bits = ~r_sync2 & 3'b010;
    end else begin
      w_row_bits = ~r_sync2;
    end
`endif
  end

  always_comb begin
    w_frame_next = r_frame;
    if (w_slot_last) begin
      case (r_state)
        ROW0:    w_frame_next[frame_idx(0, 0) +: 3] = w_row_bits;
        ROW1:    w_frame_next[frame_idx(1, 0) +: 3] = w_row_bits;
        ROW2:    w_frame_next[frame_idx(2, 0) +: 3] = w_row_bits;
        ROW3:    w_frame_next[frame_idx(3, 0) +: 3] = w_row_bits;
        default: w_frame_next = r_frame;
      endcase
    end else begin
      w_frame_next = r_frame;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= ROW0;
      r_slot  <= '0;
      r_rows  <= 4'b1110;
      r_frame <= '0;
    end else begin
      r_frame <= w_frame_next;
      if (w_slot_last) begin
        r_slot <= '0;
        case (r_state)
          ROW0:    begin r_state <= ROW1; r_rows <= 4'b1101; end
          ROW1:    begin r_state <= ROW2; r_rows <= 4'b1011; end
          ROW2:    begin r_state <= ROW3; r_rows <= 4'b0111; end
          ROW3:    begin r_state <= ROW0; r_rows <= 4'b1110; end
          default: begin r_state <= ROW0; r_rows <= 4'b1110; end
        endcase
      end else begin
        r_slot <= r_slot + SLOT_ONE;
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clock        (clock),
    .clear        (clear),
    .i_frame_valid(w_frame_valid),
    .i_frame      (w_frame_next),
    .o_committed  (w_committed)
  );

  // * and # bits are always counted; they are forced to zero when the aux feature is off.
  always_comb begin
    w_digits            = '0;
    w_digits[KEY_1_BIT] = w_committed[frame_idx(0, 0)];
    w_digits[KEY_2_BIT] = w_committed[frame_idx(0, 1)];
    w_digits[KEY_3_BIT] = w_committed[frame_idx(0, 2)];
    w_digits[KEY_4_BIT] = w_committed[frame_idx(1, 0)];
    w_digits[KEY_5_BIT] = w_committed[frame_idx(1, 1)];
    w_digits[KEY_6_BIT] = w_committed[frame_idx(1, 2)];
    w_digits[KEY_7_BIT] = w_committed[frame_idx(2, 0)];
    w_digits[KEY_8_BIT] = w_committed[frame_idx(2, 1)];
    w_digits[KEY_9_BIT] = w_committed[frame_idx(2, 2)];
    w_digits[KEY_0_BIT] = w_committed[frame_idx(3, 1)];
    w_key_count = 4'd0;
    for (int i = 0; i < FRAME_W; i++) begin
      w_key_count = w_key_count + {3'b000, w_committed[i]};
    end
    if (w_key_count == 4'd1) begin
      w_keypad_next = w_digits;
    end else begin
      w_keypad_next = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_keypad <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_keypad <= w_keypad_next;
      r_strobe <= (w_keypad_next != '0) && (r_keypad == '0);
    end
  end

`ifdef KEYPAD_AUX_KEYS_EN
  logic r_stop;
  logic r_clr;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_stop <= 1'b0;
      r_clr  <= 1'b0;
    end else begin
      r_stop <= w_committed[frame_idx(3, 0)] && (w_digits == '0);
      r_clr  <= w_committed[frame_idx(3, 2)] && (w_digits == '0);
    end
  end

  assign stop_key = r_stop;
  assign clr_key  = r_clr;
`endif

  assign rows       = r_rows;
  assign keypad     = r_keypad;
  assign key_strobe = r_strobe;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE=3) with a
// physical matrix model and a frame-history reference model.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int FRAME    = 4 * SCAN_DIV;
`ifdef KEYPAD_AUX_KEYS_EN
  localparam bit AUX = 1'b1;
`else
  localparam bit AUX = 1'b0;
`endif

  localparam int K1 = 0, K2 = 1, K3 = 2, K4 = 3, K5 = 4, K6 = 5;
  localparam int K7 = 6, K8 = 7, K9 = 8, KSTAR = 9, K0 = 10, KHASH = 11;

  logic        clock = 1'b0;
  logic        clear;
  logic [2:0]  cols;
  logic [3:0]  rows;
  logic [9:0]  keypad;
  logic        key_strobe;
  logic [11:0] pressed;
`ifdef KEYPAD_AUX_KEYS_EN
  logic        stop_key;
  logic        clr_key;
`endif

  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;
  int nz_cnt = 0;

  always #5 clock = ~clock;

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .cols      (cols),
    .rows      (rows),
    .keypad    (keypad),
    .key_strobe(key_strobe)
`ifdef KEYPAD_AUX_KEYS_EN
    ,
    .stop_key  (stop_key),
    .clr_key   (clr_key)
`endif
  );

  // Membrane matrix: a column reads low when a pressed key in a driven row shorts it.
  always_comb begin
    cols = 3'b111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!rows[r] && pressed[r * 3 + c]) cols[c] = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] kb(input int idx);
    logic [11:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Digit value of key index i is i+1 for the first nine keys, 0 for index 10.
  function automatic logic [9:0] m_decode(input logic [11:0] f);
    int n;
    int d;
    logic [9:0] k;
    n = 0;
    k = '0;
    for (int i = 0; i < 12; i++) begin
      if (f[i]) begin
        if (i == KSTAR || i == KHASH) begin
          if (AUX) n++;
        end else begin
          n++;
          d = (i == K0) ? 0 : i + 1;
          k[(d == 0) ? 0 : 10 - d] = 1'b1;
        end
      end
    end
    return (n == 1) ? k : 10'd0;
  endfunction

  logic        m_valid = 1'b0;
  int          m_ph;
  logic [11:0] m_h1, m_h2, m_cur, m_committed;
  logic [11:0] m_frames[$];
  logic [9:0]  m_keypad, m_kp_new;
  logic        m_strobe, m_stop, m_clr, m_eq;
  logic [3:0]  m_rows_exp;

  // Compare the DUT state after the last edge, then advance the model across the next edge.
  always @(negedge clock) begin
    if (m_valid) begin
      m_rows_exp = ~(4'b0001 << (m_ph / SCAN_DIV));
      chk("rows", 32'(rows), 32'(m_rows_exp));
      chk("rows_onehot", 32'($countones(~rows)), 32'd1);
      chk("keypad", 32'(keypad), 32'(m_keypad));
      chk("key_strobe", 32'(key_strobe), 32'(m_strobe));
`ifdef KEYPAD_AUX_KEYS_EN
      chk("stop_key", 32'(stop_key), 32'(m_stop));
      chk("clr_key", 32'(clr_key), 32'(m_clr));
`endif
      if (key_strobe) strobe_cnt++;
      if (keypad != 10'd0) nz_cnt++;
    end
    if (clear) begin
      m_valid = 1'b1; m_ph = 0; m_cur = '0; m_committed = '0;
      m_frames = {12'd0};
      m_keypad = '0; m_strobe = 1'b0; m_stop = 1'b0; m_clr = 1'b0;
    end else if (m_valid) begin
      m_kp_new = m_decode(m_committed);
      m_strobe = (m_kp_new != 10'd0) && (m_keypad == 10'd0);
      m_keypad = m_kp_new;
      m_stop = AUX && m_committed[KSTAR] && ((m_committed & 12'h5FF) == 12'd0);
      m_clr  = AUX && m_committed[KHASH] && ((m_committed & 12'h5FF) == 12'd0);
      if (m_ph % SCAN_DIV == SCAN_DIV - 1) begin
        for (int c = 0; c < 3; c++) m_cur[(m_ph / SCAN_DIV) * 3 + c] = m_h2[(m_ph / SCAN_DIV) * 3 + c];
        if (!AUX) begin
          m_cur[KSTAR] = 1'b0;
          m_cur[KHASH] = 1'b0;
        end
      end
      if (m_ph == FRAME - 1) begin
        m_frames.push_back(m_cur);
        if (m_frames.size() > DEBOUNCE + 1) void'(m_frames.pop_front());
        if (m_frames.size() == DEBOUNCE + 1) begin
          m_eq = 1'b1;
          foreach (m_frames[i]) if (m_frames[i] != m_cur) m_eq = 1'b0;
          if (m_eq) m_committed = m_cur;
        end
      end
      m_ph = (m_ph + 1) % FRAME;
    end
    m_h2 = m_h1;
    m_h1 = pressed;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    clear = 1'b1;
    pressed = '0;
    wait_cycles(3);
    chk("reset_rows", 32'(rows), 32'h0000000E);
    chk("reset_keypad", 32'(keypad), 32'd0);
    chk("reset_strobe", 32'(key_strobe), 32'd0);

    // Key 5 held from the first scan cycle.
    clear = 1'b0; pressed = kb(K5); strobe_cnt = 0;
    wait_cycles(5 * FRAME);
    chk("key5_code", 32'(keypad), 32'h00000020);
    chk("key5_strobes", 32'(strobe_cnt), 32'd1);
    pressed = '0;
    wait_cycles(6 * FRAME);
    chk("key5_release", 32'(keypad), 32'd0);

    // Key 0 press and release.
    strobe_cnt = 0; pressed = kb(K0);
    wait_cycles(6 * FRAME);
    chk("key0_code", 32'(keypad), 32'h00000001);
    chk("key0_strobes", 32'(strobe_cnt), 32'd1);
    strobe_cnt = 0; pressed = '0;
    wait_cycles(6 * FRAME);
    chk("key0_release", 32'(keypad), 32'd0);
    chk("key0_release_strobes", 32'(strobe_cnt), 32'd0);

    // Key 8 bouncing every 24 cycles never commits.
    strobe_cnt = 0; nz_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      pressed = pressed ^ kb(K8);
      wait_cycles(24);
    end
    pressed = '0;
    wait_cycles(6 * FRAME);
    chk("bounce_strobes", 32'(strobe_cnt), 32'd0);
    chk("bounce_nonzero_cycles", 32'(nz_cnt), 32'd0);

    // Two keys reject, then a single key is accepted.
    strobe_cnt = 0; pressed = kb(K1) | kb(K9);
    wait_cycles(6 * FRAME);
    chk("multi_code", 32'(keypad), 32'd0);
    chk("multi_strobes", 32'(strobe_cnt), 32'd0);
    pressed = kb(K1);
    wait_cycles(6 * FRAME);
    chk("key1_code", 32'(keypad), 32'h00000200);
    chk("key1_strobes", 32'(strobe_cnt), 32'd1);

    // Aux keys.
    pressed = '0;
    wait_cycles(6 * FRAME);
    strobe_cnt = 0;
`ifdef KEYPAD_AUX_KEYS_EN
    pressed = kb(KSTAR);
    wait_cycles(6 * FRAME);
    chk("star_stop", 32'(stop_key), 32'd1);
    chk("star_keypad", 32'(keypad), 32'd0);
    chk("star_strobes", 32'(strobe_cnt), 32'd0);
    pressed = kb(KSTAR) | kb(K4);
    wait_cycles(6 * FRAME);
    chk("star4_stop", 32'(stop_key), 32'd0);
    chk("star4_keypad", 32'(keypad), 32'd0);
    pressed = kb(KHASH);
    wait_cycles(6 * FRAME);
    chk("hash_clr", 32'(clr_key), 32'd1);
    chk("hash_keypad", 32'(keypad), 32'd0);
`else
    pressed = kb(KSTAR) | kb(K0) | kb(KHASH);
    wait_cycles(6 * FRAME);
    chk("star0hash_code", 32'(keypad), 32'h00000001);
    chk("star0hash_strobes", 32'(strobe_cnt), 32'd1);
`endif

    // Clear in the middle of debouncing key 3 restarts the count.
    pressed = '0; clear = 1'b1;
    wait_cycles(1);
    clear = 1'b0; pressed = kb(K3);
    wait_cycles(40);
    chk("key3_precommit", 32'(keypad), 32'd0);
    clear = 1'b1;
    wait_cycles(1);
    chk("clear_rows", 32'(rows), 32'h0000000E);
    chk("clear_keypad", 32'(keypad), 32'd0);
    chk("clear_strobe", 32'(key_strobe), 32'd0);
    clear = 1'b0; strobe_cnt = 0;
    wait_cycles(4 * FRAME);
    chk("key3_not_early", 32'(keypad), 32'd0);
    wait_cycles(1);
    chk("key3_code", 32'(keypad), 32'h00000080);
    chk("key3_strobe", 32'(key_strobe), 32'd1);
    wait_cycles(10);
    chk("key3_strobes", 32'(strobe_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
